pixel_block_collector: RTL and testbench

//  Serial-to-block front end of the JPEG encoder datapath. Accepts one pixel per

---
 rtl/pixel_block_collector.sv | 120 ++++++++++++
 tb/tb_pixel_block_collector.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pixel_block_collector.sv
// pixel_block_collector: serial-to-block front end of the JPEG encoder.
// Collects 64 raster-order pixels into an 8x8 block held in one of two
// ping-pong banks and presents the finished block as a 512-bit word.
// Pixel k of the block sits at block_data[511-8k -: 8], so pixel 0 is at the MSB.
// The optional macro PBC_LEVEL_SHIFT_EN stores each pixel as pix_in ^ 8'h80,
// which is the JPEG level shift from 0..255 to -128..127.

// One pixel position, holding that position's value for both banks.
module pbc_slot #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  wr_bank,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_bank,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [1:0][DATA_WIDTH-1:0] mem;

  // Write the accepted pixel into the bank being filled. Contents survive flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      mem <= '0;
    else if (wr_en) mem[wr_bank] <= wr_data;
  end

  assign rd_data = mem[rd_bank];

endmodule

module pixel_block_collector #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [DATA_WIDTH-1:0]       pix_in,
  input  logic                        pix_valid,
  output logic                        pix_ready,
  output logic                        block_valid,
  input  logic                        block_ready,
  output logic [DATA_WIDTH*DEPTH-1:0] block_data,
  output logic [5:0]                  fill_count
);

  localparam logic [5:0] LAST_IDX = 6'(DEPTH - 1);

  logic [1:0] bank_full, bank_full_nxt;
  logic       wr_bank, rd_bank;
  logic       accept, consume, fill_done;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] slot_q;

  // Status comes from registers only, so ready and valid never depend on inputs.
  assign pix_ready   = !bank_full[wr_bank];
  assign block_valid = bank_full[rd_bank];

  // Flush takes priority, so a pixel or a block offered in a flush cycle is dropped.
  assign accept    = pix_valid && pix_ready && !flush;
  assign consume   = block_valid && block_ready && !flush;
  assign fill_done = accept && (fill_count == LAST_IDX);

`ifdef PBC_LEVEL_SHIFT_EN
  assign wr_data = pix_in ^ {1'b1, {(DATA_WIDTH-1){1'b0}}};
`else
  assign wr_data = pix_in;
`endif

  // A completing fill and a consume always target different banks.
  // An empty write bank is required to accept, and a full read bank is
  // required to consume, so both updates can be applied in the same cycle.
  always_comb begin
    bank_full_nxt = bank_full;
    if (consume)   bank_full_nxt[rd_bank] = 1'b0;
    if (fill_done) bank_full_nxt[wr_bank] = 1'b1;
  end

  // Bank bookkeeping: fill pointer, write/read bank select and full flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bank_full  <= 2'b00;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      fill_count <= '0;
    end else if (flush) begin
      bank_full  <= 2'b00;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      fill_count <= '0;
    end else begin
      bank_full <= bank_full_nxt;
      // fill_count wraps from 63 to 0 on the pixel that completes a block.
      if (accept)    fill_count <= fill_count + 6'd1;
      if (fill_done) wr_bank    <= ~wr_bank;
      if (consume)   rd_bank    <= ~rd_bank;
    end
  end

  // One storage slot per pixel position, packed MSB-first onto block_data.
  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    logic wr_en;
    assign wr_en = accept && (fill_count == 6'(k));

    pbc_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_bank (wr_bank),
      .wr_data (wr_data),
      .rd_bank (rd_bank),
      .rd_data (slot_q[k])
    );

    assign block_data[(DEPTH-1-k)*DATA_WIDTH +: DATA_WIDTH] = slot_q[k];
  end

endmodule

// File: tb/tb_pixel_block_collector.sv
// Randomized bench for pixel_block_collector. The reference model treats the
// two banks as a queue of up to two finished blocks plus one partial block.
module tb_pixel_block_collector;

  logic         clock = 1'b0;
  logic         reset, flush, pix_valid, block_ready;
  logic [7:0]   pix_in;
  logic         pix_ready, block_valid;
  logic [511:0] block_data;
  logic [5:0]   fill_count;

  pixel_block_collector dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .pix_in      (pix_in),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .block_data  (block_data),
    .fill_count  (fill_count)
  );

  always #5 clock = ~clock;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Model state: finished blocks waiting downstream, plus the block being filled.
  logic [511:0] mq[$];
  logic [511:0] m_part;
  int           m_cnt;

  task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] stored(input logic [7:0] p);
`ifdef PBC_LEVEL_SHIFT_EN
    return p ^ 8'h80;
`else
    return p;
`endif
  endfunction

  task automatic model_clear();
    mq.delete();
    m_cnt  = 0;
    m_part = '0;
  endtask

  task automatic check_outputs();
    chk("pix_ready", pix_ready, mq.size() < 2);
    chk("block_valid", block_valid, mq.size() > 0);
    chk("fill_count", fill_count, m_cnt);
    if (mq.size() > 0) chk("block_data", block_data, mq[0]);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic step(input logic pv, input logic [7:0] px, input logic br, input logic fl);
    logic acc, cons;
    pix_valid   = pv;
    pix_in      = px;
    block_ready = br;
    flush       = fl;
    acc  = pv && (mq.size() < 2) && !fl;
    cons = br && (mq.size() > 0) && !fl;
    @(posedge clock);
    #1;
    if (fl) begin
      model_clear();
    end else begin
      if (cons) void'(mq.pop_front());
      if (acc) begin
        m_part[511 - 8*m_cnt -: 8] = stored(px);
        m_cnt++;
        if (m_cnt == 64) begin
          mq.push_back(m_part);
          m_cnt = 0;
        end
      end
    end
    pix_valid   = 1'b0;
    block_ready = 1'b0;
    flush       = 1'b0;
    check_outputs();
  endtask

  // Reset asserted mid-cycle, away from the clock edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    model_clear();
    #1;
    chk("rst_data", block_data, '0);
    chk("rst_valid", block_valid, 1'b0);
    chk("rst_fill", fill_count, 6'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    check_outputs();
  endtask

  initial begin
    logic br_mode;
    reset = 1'b1; flush = 1'b0; pix_valid = 1'b0; block_ready = 1'b0; pix_in = '0;
    model_clear();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("init_data", block_data, '0);
    chk("init_ready", pix_ready, 1'b1);
    check_outputs();

    // Test 1: pixels 0..63 back to back, block_ready held high.
    for (int i = 0; i < 64; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
    chk("t1_valid", block_valid, 1'b1);
    chk("t1_pix0", block_data[511:504], stored(8'h00));
    chk("t1_pix63", block_data[7:0], stored(8'h3F));
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t1_taken", block_valid, 1'b0);

    // Test 2: downstream stalled; two banks fill and then input is held off.
    for (int i = 0; i < 130; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    chk("t2_stall", pix_ready, 1'b0);
    chk("t2_fill", fill_count, 6'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t2_ready", pix_ready, 1'b1);
    chk("t2_bank1", block_valid, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Test 3: reset in the middle of a fill.
    for (int i = 0; i < 30; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 64; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    chk("t3_valid", block_valid, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Test 4: last pixel of bank B lands in the same cycle bank A is consumed.
    for (int i = 0; i < 127; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'($urandom), 1'b1, 1'b0);
    chk("t4_valid", block_valid, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t4_empty", block_valid, 1'b0);

    // Test 5: flush in the middle of a fill.
    for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t5_fill", fill_count, 6'd0);
    chk("t5_valid", block_valid, 1'b0);
    for (int i = 0; i < 64; i++) step(1'b1, 8'(i + 100), 1'b0, 1'b0);
    chk("t5_pix0", block_data[511:504], stored(8'd100));
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Test 6: extreme pixel values and the optional level shift.
    do_reset();
    step(1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    for (int i = 2; i < 64; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
`ifdef PBC_LEVEL_SHIFT_EN
    chk("t6_p0", block_data[511:504], 8'h80);
    chk("t6_p1", block_data[503:496], 8'h7F);
`else
    chk("t6_p0", block_data[511:504], 8'h00);
    chk("t6_p1", block_data[503:496], 8'hFF);
`endif
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic with bursty downstream stalls and occasional flushes.
    br_mode = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 99) == 0) br_mode = ~br_mode;
      step($urandom_range(0, 3) != 0, 8'($urandom),
           br_mode ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0),
           $urandom_range(0, 299) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
